// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - tick-paced parallel-in serial-out shifter with LED mirror; optional parity bit under PISO_PARITY_EN
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            tick,
    input  logic                            load_valid,
    input  logic [WIDTH-1:0]                load_data,
    output logic                            load_ready,
    output logic                            s_out,
    output logic                            s_valid,
    output logic                            busy,
    output logic                            done,
    output logic [$clog2(WIDTH+2)-1:0]      bits_left,
    output logic [WIDTH-1:0]                leds
);

    localparam int BLW = $clog2(WIDTH + 2);
`ifdef PISO_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] shreg;
    logic [BLW-1:0]   count;
    logic             end_bit;
    logic             last_bit;

`ifdef PISO_PARITY_EN
    logic             par;
`endif

    assign end_bit  = (LSB_FIRST != 0) ? shreg[0] : shreg[WIDTH-1];
    assign last_bit = (count == BLW'(1));

    // State register; reset always lands in IDLE, so an aborted transfer never reaches DONE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and output decode; outputs depend only on registers, never on inputs
    always_comb begin
        state_nx   = state;
        load_ready = 1'b0;
        busy       = 1'b0;
        s_valid    = 1'b0;
        s_out      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                busy    = 1'b1;
                s_valid = 1'b1;
`ifdef PISO_PARITY_EN
                s_out   = last_bit ? par : end_bit;
`else
                s_out   = end_bit;
`endif
                if (tick && last_bit) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Shift datapath: capture on accept, shift and count down on tick, clear outside SHIFT
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg <= '0;
            count <= '0;
`ifdef PISO_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        shreg <= load_data;
                        count <= BLW'(NBITS);
`ifdef PISO_PARITY_EN
                        par   <= ^load_data;
`endif
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        count <= count - BLW'(1);
                        if (last_bit) begin
                            shreg <= '0;
                        end else if (LSB_FIRST != 0) begin
                            shreg <= shreg >> 1;
                        end else begin
                            shreg <= shreg << 1;
                        end
                    end
                end
                default: begin
                    shreg <= '0;
                    count <= '0;
                end
            endcase
        end
    end

    assign bits_left = count;
    assign leds      = shreg;

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - randomized bench for piso_serializer, LSB-first and MSB-first instances side by side
module tb_piso_serializer;

    localparam int W = 8;
`ifdef PISO_PARITY_EN
    localparam int N = W + 1;
`else
    localparam int N = W;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         tick;
    logic         load_valid;
    logic [W-1:0] load_data;

    logic         rdy_l, sout_l, sval_l, busy_l, done_l;
    logic [3:0]   bl_l;
    logic [W-1:0] leds_l;
    logic         rdy_m, sout_m, sval_m, busy_m, done_m;
    logic [3:0]   bl_m;
    logic [W-1:0] leds_m;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .LSB_FIRST(1)) u_lsb (
        .clk(clk), .rst_n(rst_n), .tick(tick), .load_valid(load_valid), .load_data(load_data),
        .load_ready(rdy_l), .s_out(sout_l), .s_valid(sval_l), .busy(busy_l), .done(done_l),
        .bits_left(bl_l), .leds(leds_l)
    );

    piso_serializer #(.WIDTH(W), .LSB_FIRST(0)) u_msb (
        .clk(clk), .rst_n(rst_n), .tick(tick), .load_valid(load_valid), .load_data(load_data),
        .load_ready(rdy_m), .s_out(sout_m), .s_valid(sval_m), .busy(busy_m), .done(done_m),
        .bits_left(bl_m), .leds(leds_m)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // k-th bit on the wire: data bits in the chosen order, then the even-parity bit
    function automatic logic exp_bit(input logic [W-1:0] word, input bit lsb, input int k);
        if (k >= W) return ^word;
        return lsb ? word[k] : word[W-1-k];
    endfunction

    // Remaining payload after k bits have left, zero-filled from the far end
    function automatic logic [W-1:0] exp_leds(input logic [W-1:0] word, input bit lsb, input int k);
        if (k >= W) return '0;
        return lsb ? (word >> k) : (word << k);
    endfunction

    // Packed view {load_ready, s_out, s_valid, busy, done, bits_left, leds}
    function automatic logic [16:0] expect_vec(input bit shifting, input bit dn, input bit rdy,
                                               input logic [W-1:0] word, input bit lsb, input int k);
        logic [3:0] bl;
        bl = shifting ? 4'(N - k) : 4'd0;
        return {rdy, shifting ? exp_bit(word, lsb, k) : 1'b0, shifting, shifting, dn, bl,
                shifting ? exp_leds(word, lsb, k) : 8'h00};
    endfunction

    task automatic chk(input string tag, input bit shifting, input bit dn, input bit rdy,
                       input logic [W-1:0] word, input int k);
        check($sformatf("%s_lsb w=%0h k=%0d", tag, word, k),
              {15'd0, rdy_l, sout_l, sval_l, busy_l, done_l, bl_l, leds_l},
              {15'd0, expect_vec(shifting, dn, rdy, word, 1'b1, k)});
        check($sformatf("%s_msb w=%0h k=%0d", tag, word, k),
              {15'd0, rdy_m, sout_m, sval_m, busy_m, done_m, bl_m, leds_m},
              {15'd0, expect_vec(shifting, dn, rdy, word, 1'b0, k)});
    endtask

    // One transfer: period 0 = random ticks, otherwise a tick every period cycles.
    // junk holds load_valid with 8'h3C while busy; abort_at>0 resets after that many ticks.
    task automatic do_xfer(input logic [W-1:0] word, input int period, input bit tick_acc,
                           input bit junk, input int abort_at);
        int k;
        int cyc;
        bit t;
        @(negedge clk);
        chk("idle", 1'b0, 1'b0, 1'b1, word, 0);
        load_valid = 1'b1;
        load_data  = word;
        tick       = tick_acc;
        k   = 0;
        cyc = 0;
        while (k < N && cyc < 400) begin
            @(negedge clk);
            chk("shift", 1'b1, 1'b0, 1'b0, word, k);
            if (abort_at > 0 && k == abort_at) begin
                rst_n      = 1'b0;
                load_valid = 1'b1;
                tick       = 1'b1;
                @(negedge clk);
                chk("abort", 1'b0, 1'b0, 1'b1, word, 0);
                rst_n      = 1'b1;
                load_valid = 1'b0;
                tick       = 1'b0;
                @(negedge clk);
                chk("abort_post", 1'b0, 1'b0, 1'b1, word, 0);
                return;
            end
            load_valid = junk;
            load_data  = junk ? 8'h3C : 8'($urandom);
            t = (period == 0) ? ($urandom_range(0, 2) == 0) : ((cyc % period) == period - 1);
            tick = t;
            if (t) k++;
            cyc++;
        end
        check($sformatf("ticks_delivered w=%0h", word), k, N);
        @(negedge clk);
        chk("done", 1'b0, 1'b1, 1'b0, word, 0);
        load_valid = 1'b0;
        tick       = 1'($urandom_range(0, 1));
    endtask

    initial begin
        rst_n      = 1'b0;
        load_valid = 1'b1;
        load_data  = 8'hFF;
        tick       = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset", 1'b0, 1'b0, 1'b1, 8'h00, 0);
        rst_n      = 1'b1;
        load_valid = 1'b0;
        tick       = 1'b0;

        do_xfer(8'hA5, 4, 1'b0, 1'b0, 0);
        do_xfer(8'h81, 4, 1'b1, 1'b0, 0);
        do_xfer(8'hA5, 1, 1'b1, 1'b1, 0);
        do_xfer(8'h3C, 3, 1'b0, 1'b0, 0);
        do_xfer(8'h07, 2, 1'b0, 1'b0, 0);
        do_xfer(8'h03, 0, 1'b1, 1'b1, 0);
        do_xfer(8'hC3, 2, 1'b0, 1'b0, 3);
        do_xfer(8'h5A, 1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 8; i++) begin
            do_xfer(8'($urandom), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), (i == 5) ? 1 : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
